// File: rtl/pe_tensor_ctrl_if.sv
// pe_tensor_ctrl_if: job, filter, ifmap and result handshake bundle of the tensor sequencer
interface pe_tensor_ctrl_if #(
    parameter int N     = 1,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_windows;
    logic             reuse_w;
    logic             busy;
    logic             done;
    logic             filt_valid;
    logic             filt_ready;
    logic             wb_write_en;
    logic             if_valid;
    logic             if_ready;
    logic [16*N-1:0]  psum_in;
    logic             out_valid;
    logic             out_ready;
    logic [16*N-1:0]  psum_out;
    logic [31:0]      stall_cnt;

    modport master (
        output start, num_windows, reuse_w, filt_valid, if_valid, psum_in, out_ready,
        input  busy, done, filt_ready, wb_write_en, if_ready, out_valid, psum_out, stall_cnt
    );

    modport slave (
        input  start, num_windows, reuse_w, filt_valid, if_valid, psum_in, out_ready,
        output busy, done, filt_ready, wb_write_en, if_ready, out_valid, psum_out, stall_cnt
    );
endinterface

// File: rtl/pe_tensor_ctrl.sv
// pe_tensor_ctrl: weight-load / window-stream / psum-capture sequencer; PE_CTRL_PERF_CNT_EN enables the stall counter
module pe_tensor_ctrl #(
    parameter int N     = 1,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    pe_tensor_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_win_q, n_win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_loaded_q, w_loaded_d;
    logic             out_valid_q, out_valid_d;
    logic [16*N-1:0]  psum_q, psum_d;
    logic             accept;

    assign bus.busy        = state_q != IDLE;
    assign bus.done        = state_q == DONE;
    assign bus.filt_ready  = state_q == LOAD_W;
    assign bus.wb_write_en = state_q == LOAD_W && bus.filt_valid;
    assign bus.if_ready    = state_q == STREAM && (!out_valid_q || bus.out_ready);
    assign bus.out_valid   = out_valid_q;
    assign bus.psum_out    = psum_q;
    assign accept          = bus.if_valid && bus.if_ready;

    // next-state, window counting and output-slot update
    always_comb begin
        state_d     = state_q;
        n_win_d     = n_win_q;
        cnt_d       = cnt_q;
        w_loaded_d  = w_loaded_q;
        out_valid_d = out_valid_q;
        psum_d      = psum_q;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (accept) begin
            psum_d      = bus.psum_in;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: if (bus.start) begin
                n_win_d = bus.num_windows;
                cnt_d   = '0;
                state_d = bus.num_windows == '0 ? DONE :
                          (bus.reuse_w && w_loaded_q) ? STREAM : LOAD_W;
            end
            LOAD_W: if (bus.filt_valid) begin
                w_loaded_d = 1'b1;
                state_d    = STREAM;
            end
            STREAM:  if (accept && cnt_q == n_win_q - CNT_W'(1)) state_d = DRAIN;
            DRAIN:   if (!out_valid_q || bus.out_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            n_win_q     <= '0;
            cnt_q       <= '0;
            w_loaded_q  <= 1'b0;
            out_valid_q <= 1'b0;
            psum_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_win_q     <= n_win_d;
            cnt_q       <= cnt_d;
            w_loaded_q  <= w_loaded_d;
            out_valid_q <= out_valid_d;
            psum_q      <= psum_d;
        end
    end

`ifdef PE_CTRL_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    // count STREAM cycles without a window transfer, saturating, restarted per job
    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && bus.start) stall_d = '0;
        else if (state_q == STREAM && !accept && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    // stall counter register
    always_ff @(posedge clk) begin
        if (!rst) stall_q <= '0;
        else stall_q <= stall_d;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pe_tensor_ctrl.sv
// tb_pe_tensor_ctrl: directed scoreboard bench for the tensor sequencer
module tb_pe_tensor_ctrl;
    localparam int N     = 1;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_tensor_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();
    pe_tensor_ctrl #(.N(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, failures = 0, cyc = 0;
    int wb_cnt = 0, fr_cnt = 0, ir_cnt = 0, ov_cnt = 0, busy_cnt = 0, done_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: scoreboard pops, latency and hold checks, event counters
    initial begin
        logic prev_acc, prev_hold;
        logic [15:0] prev_val;
        prev_acc = 1'b0;
        prev_hold = 1'b0;
        prev_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wb_cnt   += int'(bus.wb_write_en);
                fr_cnt   += int'(bus.filt_ready);
                ir_cnt   += int'(bus.if_ready);
                ov_cnt   += int'(bus.out_valid);
                busy_cnt += int'(bus.busy);
                done_cnt += int'(bus.done);
                if (prev_acc) chk("latency_valid", 32'(bus.out_valid), 32'd1);
                if (prev_hold) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_data", 32'(bus.psum_out), 32'(prev_val));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out act=%0h exp=none", bus.psum_out);
                    end else chk("psum_out", 32'(bus.psum_out), 32'(exp_q.pop_front()));
                end
            end
            prev_acc  = rst && bus.if_valid && bus.if_ready;
            prev_hold = rst && bus.out_valid && !bus.out_ready;
            prev_val  = bus.psum_out;
        end
    end

    task automatic check_reset();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_filt_ready", 32'(bus.filt_ready), 32'd0);
        chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst_wb_write_en", 32'(bus.wb_write_en), 32'd0);
        chk("rst_psum_out", 32'(bus.psum_out), 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    endtask

    task automatic start_job(input int nw, input logic rw);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.num_windows = CNT_W'(nw);
        bus.reuse_w = rw;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_win(input logic [15:0] v, output int acc);
        int t;
        t = 0;
        acc = -1;
        bus.if_valid = 1'b1;
        bus.psum_in = v;
        @(negedge clk);
        while (!bus.if_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("win_accept", 32'(bus.if_ready), 32'd1);
        if (bus.if_ready) begin
            exp_q.push_back(v);
            acc = cyc + 1;
        end
        @(posedge clk); #1;
        bus.if_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input int exp_stall);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        if (exp_cyc >= 0) chk("done_cycle", 32'(cyc), 32'(exp_cyc));
`ifdef PE_CTRL_PERF_CNT_EN
        if (exp_stall >= 0) chk("stall_cnt", bus.stall_cnt, 32'(exp_stall));
`else
        chk("stall_cnt_off", bus.stall_cnt, 32'(exp_stall * 0));
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, wb0, fr0, ir0, ov0, busy0, done0;
        bus.start = 1'b0;
        bus.num_windows = '0;
        bus.reuse_w = 1'b0;
        bus.filt_valid = 1'b1;
        bus.if_valid = 1'b0;
        bus.psum_in = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b1;

        // basic job: 3 windows, full throughput
        wb0 = wb_cnt;
        start_job(3, 1'b0);
        send_win(16'd5, a0);
        send_win(16'd7, a1);
        send_win(16'd9, a2);
        chk("throughput", 32'(a2 - a0), 32'd2);
        wait_done(a2 + 1, 0);
        chk("basic_wb_pulses", 32'(wb_cnt - wb0), 32'd1);

        // backpressure with weight reuse
        wb0 = wb_cnt;
        fr0 = fr_cnt;
        start_job(3, 1'b1);
        send_win(16'd11, a0);
        bus.out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_if_ready", 32'(bus.if_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold", 32'(bus.psum_out), 32'd11);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_win(16'd13, a1);
        send_win(16'd15, a2);
        wait_done(-1, -1);
        chk("reuse_wb", 32'(wb_cnt - wb0), 32'd0);
        chk("reuse_filt_ready", 32'(fr_cnt - fr0), 32'd0);

        // fresh reset: reuse_w still loads
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wb0 = wb_cnt;
        fr0 = fr_cnt;
        start_job(1, 1'b1);
        send_win(16'd21, a0);
        wait_done(-1, 0);
        chk("reload_wb", 32'(wb_cnt - wb0), 32'd1);
        chk("reload_filt_ready", 32'(fr_cnt - fr0), 32'd1);

        // zero-length job
        busy0 = busy_cnt;
        fr0 = fr_cnt;
        ir0 = ir_cnt;
        ov0 = ov_cnt;
        start_job(0, 1'b0);
        wait_done(-1, 0);
        chk("zero_busy", 32'(busy_cnt - busy0), 32'd1);
        chk("zero_filt_ready", 32'(fr_cnt - fr0), 32'd0);
        chk("zero_if_ready", 32'(ir_cnt - ir0), 32'd0);
        chk("zero_out_valid", 32'(ov_cnt - ov0), 32'd0);

        // reset mid-stream after 2 of 5 windows
        start_job(5, 1'b1);
        send_win(16'd31, a0);
        send_win(16'd33, a1);
        done0 = done_cnt;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
        wb0 = wb_cnt;
        fr0 = fr_cnt;
        start_job(1, 1'b1);
        send_win(16'd35, a0);
        wait_done(-1, 0);
        chk("abort_reload_wb", 32'(wb_cnt - wb0), 32'd1);
        chk("abort_reload_filt", 32'(fr_cnt - fr0), 32'd1);

        // 3 idle STREAM cycles in a 2-window job
        start_job(2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send_win(16'd41, a0);
        send_win(16'd43, a1);
        wait_done(-1, 3);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_tensor_ctrl.md
Name: pe_tensor_ctrl

Overview:
- Sequencer for the N-lane 3x3 conv tensor: weight-buffer load, ifmap window stream, psum capture.
- One job = one filter load (`wb_write_en` pulse), then `num_windows` ifmap windows.
- Each accepted window's tensor result is registered into a valid/ready output slot.
- Sits between the fetch/DMA front end and the tensor; it owns every handshake around the combinational PE/accumulator path.

Parameters:
- N, 1, number of PE lanes; width of `psum_in` and `psum_out` is 16*N.
- CNT_W, 16, width of the window-count configuration and the internal window counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- start  input  1  job start pulse; sampled only in IDLE.
- num_windows  input  CNT_W  windows in the job; sampled on start.
- reuse_w  input  1  skip the filter load if weights are already resident; sampled on start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at job end.
- filt_valid  input  1  filter word available from fetch.
- filt_ready  output  1  controller accepts the filter word.
- wb_write_en  output  1  tensor weight-buffer write strobe.
- if_valid  input  1  ifmap window presented to the tensor.
- if_ready  output  1  controller accepts the window.
- psum_in  input  16*N  tensor `psumOut` (combinational from the current ifmap).
- out_valid  output  1  `psum_out` holds a result.
- out_ready  input  1  downstream accepts the result.
- psum_out  output  16*N  registered result.
- stall_cnt  output  32  performance counter (see Optional Feature).

Behaviour:
- Reset (`rst`=0 at a clk edge): state=IDLE; `busy`, `done`, `out_valid`, `filt_ready`, `if_ready`, `wb_write_en` = 0; `psum_out`=0; window counter=0; `w_loaded`=0; `stall_cnt`=0.
  - Reset mid-job abandons the job with no `done` pulse; any pending result is dropped.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - On `start`: latch `num_windows` into `n_win` and clear the counter.
  - If `num_windows`==0: go to DONE.
  - Else if `reuse_w`=1 and `w_loaded`=1: go to STREAM.
  - Else: go to LOAD_W.
  - `start` outside IDLE is ignored.
- LOAD_W:
  - `filt_ready`=1.
  - `wb_write_en` = `filt_valid` (combinational), so the buffer latches at the same edge.
  - On handshake: set `w_loaded`=1 and go to STREAM. The first window can be accepted in the cycle after the load edge.
- STREAM:
  - `if_ready` = !`out_valid` || `out_ready`.
  - On `if_valid` && `if_ready`:
    - `psum_out` <= `psum_in`; `out_valid` <= 1; counter++.
    - If counter==`n_win`-1, go to DRAIN.
  - Latency: window accepted at edge k → result valid after edge k (one cycle).
- Output slot, all states:
  - On `out_valid` && `out_ready` with no new capture: `out_valid` <= 0.
  - Simultaneous drain and capture: `out_valid` stays 1 and `psum_out` takes the new value, giving full throughput of one window per cycle.
- DRAIN: `if_ready`=0; go to DONE once `out_valid`=0 or `out_valid` && `out_ready`.
- DONE: `done`=1 for exactly one cycle, then IDLE. `busy`=0 in the same cycle as the return to IDLE.
- `busy`=1 in LOAD_W, STREAM, DRAIN and DONE.
- Counter arithmetic: unsigned CNT_W. Maximum job length 2^CNT_W−1 windows; no wrap inside a job.
- `filt_ready`=0 and `wb_write_en`=0 outside LOAD_W; `if_ready`=0 outside STREAM.
- `w_loaded` is cleared only by reset.

Optional Feature:
- Macro: PE_CTRL_PERF_CNT_EN.
- Defined: `stall_cnt` increments by 1 each cycle in STREAM where `if_valid`=0 or `if_ready`=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared on reset and on each accepted `start`.
- Undefined: `stall_cnt` is tied to 0 and no counter logic is synthesised.

Test Plan:
- Basic job: reset, N=1, `start` with `num_windows`=3, `reuse_w`=0, `filt_valid`=1, `if_valid`=1, `out_ready`=1, `psum_in`=5,7,9 per window.
  - `wb_write_en` pulses exactly one cycle.
  - 3 results 5,7,9, each 1 cycle after its accept.
  - `done` pulse 1 cycle after the last result drains; 1 ifmap/cycle throughput.
- Backpressure: `out_ready`=0 for 4 cycles after the first result.
  - `if_ready` low those 4 cycles and `psum_out` held.
  - No window lost; `out_valid` never drops while unacknowledged.
- Weight reuse: second `start` with `reuse_w`=1 → no `wb_write_en` and no LOAD_W (`filt_ready` stays 0). After a fresh reset, `reuse_w`=1 still loads.
- Zero-length job: `num_windows`=0 → `busy` 1 cycle, `done` pulse, no `filt_ready`/`if_ready`/`out_valid`.
- Reset mid-STREAM after 2 of 5 windows: all outputs return to their reset values next cycle, no `done`. Next `start` with `reuse_w`=1 reloads the filter.
- With PE_CTRL_PERF_CNT_EN defined: `if_valid` low 3 cycles in a 2-window job → `stall_cnt`=3 at `done`. Without the macro, `stall_cnt`=0 throughout.
